// File: rtl/alu_multicycle.sv
`default_nettype none
// +------------------------------------------------------------------------------------------+
// | alu_multicycle: valid/ready MIPS ALU, single-cycle logic ops plus iterative multu/divu.   |
// | Define ALU_DIV_EN to build the restoring divider. Revision: 1.0                          |
// +------------------------------------------------------------------------------------------+
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  localparam logic [3:0] c_op_and   = 4'b0000;
  localparam logic [3:0] c_op_or    = 4'b0001;
  localparam logic [3:0] c_op_add   = 4'b0010;
  localparam logic [3:0] c_op_sub   = 4'b0110;
  localparam logic [3:0] c_op_slt   = 4'b0111;
  localparam logic [3:0] c_op_xor   = 4'b0011;
  localparam logic [3:0] c_op_nor   = 4'b1100;
  localparam logic [3:0] c_op_sll   = 4'b1000;
  localparam logic [3:0] c_op_srl   = 4'b1001;
  localparam logic [3:0] c_op_sra   = 4'b1010;
  localparam logic [3:0] c_op_sltu  = 4'b1011;
  localparam logic [3:0] c_op_multu = 4'b1101;
`ifdef ALU_DIV_EN
  localparam logic [3:0] c_op_divu  = 4'b1110;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_opnd;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_iterative;
  logic             w_last;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_single;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;

  assign w_accept = in_valid & in_ready;
  assign w_is_mul = (aluctrl == c_op_multu);
  assign w_last   = (r_cnt == c_last);
  assign w_sh     = b[SH_W-1:0];

`ifdef ALU_DIV_EN
  logic             r_is_div;
  logic             r_dbz;
  logic             w_is_div;
  logic             w_b_zero;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;

  assign w_is_div    = (aluctrl == c_op_divu);
  assign w_b_zero    = (b == '0);
  assign w_iterative = w_is_mul | (w_is_div & ~w_b_zero);
  assign div_by_zero = r_dbz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_dbz <= w_is_div & w_b_zero;
    end
  end
`else
  assign w_iterative = w_is_mul;
  assign div_by_zero = 1'b0;
`endif

  always_comb begin
    w_single = '0;
    case (aluctrl)
      c_op_and:  w_single = a & b;
      c_op_or:   w_single = a | b;
      c_op_add:  w_single = a + b;
      c_op_sub:  w_single = a - b;
      c_op_slt:  w_single = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      c_op_xor:  w_single = a ^ b;
      c_op_nor:  w_single = ~(a | b);
      c_op_sll:  w_single = a << w_sh;
      c_op_srl:  w_single = a >> w_sh;
      c_op_sra:  w_single = $signed(a) >>> w_sh;
      c_op_sltu: w_single = {{(WIDTH-1){1'b0}}, (a < b)};
      default:   w_single = '0;
    endcase
  end

  // One iteration step. Multiply shifts {acc, mq} right; divide shifts it left.
  always_comb begin
    w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opnd} : '0);
    w_step_hi = w_mul_sum[WIDTH:1];
    w_step_lo = {w_mul_sum[0], r_mq[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    w_div_shift = {r_acc, r_mq[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    if (r_is_div) begin
      if (!w_div_diff[WIDTH]) begin
        w_step_hi = w_div_diff[WIDTH-1:0];
        w_step_lo = {r_mq[WIDTH-2:0], 1'b1};
      end else begin
        w_step_hi = w_div_shift[WIDTH-1:0];
        w_step_lo = {r_mq[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_iterative ? ST_ITER : ST_DONE;
      ST_ITER: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b1;
      r_acc       <= '0;
      r_mq        <= '0;
      r_opnd      <= '0;
      r_cnt       <= '0;
`ifdef ALU_DIV_EN
      r_is_div    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            r_acc <= '0;
            if (w_is_mul) begin
              r_mq   <= b;
              r_opnd <= a;
`ifdef ALU_DIV_EN
              r_is_div <= 1'b0;
            end else if (w_is_div && w_b_zero) begin
              r_result    <= '1;
              r_result_hi <= a;
              r_zero      <= 1'b0;
            end else if (w_is_div) begin
              r_mq     <= a;
              r_opnd   <= b;
              r_is_div <= 1'b1;
`endif
            end else begin
              r_result    <= w_single;
              r_result_hi <= '0;
              r_zero      <= (w_single == '0);
            end
          end
        end
        ST_ITER: begin
          r_acc <= w_step_hi;
          r_mq  <= w_step_lo;
          r_cnt <= r_cnt + c_one;
          if (w_last) begin
            r_result    <= w_step_lo;
            r_result_hi <= w_step_hi;
            r_zero      <= (w_step_lo == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
